mant_divider_seq: RTL and testbench
===================================

Name: mant_divider_seq

Overview:
- Sequential unsigned mantissa divider; the inverse datapath of the team's sequential mantissa multiplier. It serves the FP divide path of the floating-point unit.
- Computes q = floor(a * 2^(QBITS-1) / b) one quotient bit per clock using a restoring algorithm.
- Provides a sticky bit for rounding and flags for divide-by-zero and overflow.
- The downstream rounding/normalise stage consumes q and sticky when ready is high.

Parameters:
- WIDTH, 24: operand width in bits; the hidden bit is included by the caller.
- QBITS, WIDTH+2: quotient bits produced. One integer bit, WIDTH fraction bits and one guard bit.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  request pulse; sampled only in IDLE or DONE.
- a  in  WIDTH  dividend, unsigned; sampled on the accepting edge.
- b  in  WIDTH  divisor, unsigned; sampled on the accepting edge.
- q  out  QBITS  quotient.
- sticky  out  1  1 when the final remainder is non-zero.
- busy  out  1  high while in RUN.
- ready  out  1  high in DONE; held until the next accepted start or reset.
- dbz  out  1  divide-by-zero flag, valid while ready=1.
- ovf  out  1  overflow flag (a >= 2*b), valid while ready=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - q, sticky, busy, ready, dbz and ovf all 0.
  - Internal remainder, divisor copy and counter cleared.
  - Reset asserted mid-operation aborts the operation immediately; no partial result is visible.
- States: IDLE, RUN, DONE. All outputs are registered.
- start accepted (edge E0, state IDLE or DONE):
  - Clear ready, dbz, ovf and q.
  - If b==0: next state DONE with dbz=1, q=all ones, sticky=0, ovf=0.
  - Else if a >= 2*b (compare at WIDTH+1 bits): next state DONE with ovf=1, q=all ones, sticky=0.
  - Otherwise: rem(WIDTH+1 bits)=a, d=b, cnt=QBITS-1, next state RUN, busy=1.
- RUN, every edge:
  - If rem >= d: the quotient bit is 1 and rem = rem - d. Otherwise the bit is 0.
  - The bit shifts into q LSB-first-in (MSB produced first); then rem = rem << 1, truncated to WIDTH+1 bits (rem < 2d always holds).
  - When cnt==0 this is the last bit: next state DONE, busy=0, ready=1, sticky = OR of the post-subtract remainder.
  - Otherwise cnt decrements.
- Latency:
  - Normal operation: ready is high after edge E0+QBITS (26 cycles at the defaults).
  - dbz/ovf short-circuit: ready is high after edge E0+1.
- start during RUN is ignored; operands are not re-sampled.
- start in DONE is accepted as a new operation. ready falls after that edge; there is no idle bubble.
- start=0 in DONE: hold all results indefinitely.
- a==0 with b!=0 is a normal run: q=0, sticky=0, full latency.
- Normalised mantissas (MSB set on both) never trigger ovf. The quotient MSB (bit QBITS-1) set means a>=b; otherwise bit QBITS-2 is set.

Decomposition:
- Shared FPU package holds:
  - mantissa width constant (24);
  - QBITS derivation;
  - state enum {IDLE, RUN, DONE}.
- One natural sub-module: div_step (combinational compare/subtract/shift of one restoring iteration: rem, d in; bit, next_rem out). The top-level holds the FSM, counter and registers.

Test Plan:
- a=0x800000, b=0x800000 -> after 26 cycles: q=0x2000000, sticky=0, dbz=0, ovf=0, ready=1.
- a=0xC00000, b=0x800000 -> q=0x3000000, sticky=0. Then a=0x800000, b=0xC00000 issued in DONE -> q=0x1555555, sticky=1, ready low for exactly 26 cycles.
- a=0xFFFFFF, b=0x800000 -> q=0x3FFFFFC, sticky=0. A start pulse with other operands at cycle 10 of RUN is ignored; the result is unchanged.
- b=0x000000, a=0x123456 -> one cycle later: ready=1, dbz=1, q=0x3FFFFFF, ovf=0.
- a=0x000002, b=0x000001 -> one cycle later: ready=1, ovf=1, q=0x3FFFFFF, dbz=0.
- Drive reset=0 asynchronously (between clock edges) at cycle 12 of a run -> all outputs 0 immediately. After release, a new start with a=b=0x800000 completes normally.

Source files
------------

// File: rtl/mant_divider_seq_pkg.sv
// rtl/mant_divider_seq_pkg.sv - shared FPU mantissa constants and divider state encoding
package mant_divider_seq_pkg;

  localparam int MANT_WIDTH = 24;

  // One integer bit, the mantissa fraction bits and one guard bit.
  function automatic int qbits_of(input int width);
    return width + 2;
  endfunction

  localparam int MANT_QBITS = qbits_of(MANT_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mant_divider_seq_if.sv
// rtl/mant_divider_seq_if.sv - request/result bundle between FP divide path and mantissa divider
interface mant_divider_seq_if
  import mant_divider_seq_pkg::*;
#(
  parameter int WIDTH = MANT_WIDTH,
  parameter int QBITS = WIDTH + 2
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [QBITS-1:0] q;
  logic             sticky;
  logic             busy;
  logic             ready;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, a, b,
    input  q, sticky, busy, ready, dbz, ovf
  );

  modport slave (
    input  start, a, b,
    output q, sticky, busy, ready, dbz, ovf
  );

endinterface

// File: rtl/mant_divider_seq_div_step.sv
// rtl/mant_divider_seq_div_step.sv - one restoring division iteration: compare, subtract, shift
module mant_divider_seq_div_step
  import mant_divider_seq_pkg::*;
#(
  parameter int WIDTH = MANT_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_bit,
  output logic [WIDTH:0]   o_sub_rem,
  output logic [WIDTH:0]   o_next_rem
);

  logic [WIDTH:0] w_d_ext;

  assign w_d_ext   = {1'b0, i_d};
  assign o_bit     = (i_rem >= w_d_ext);
  assign o_sub_rem = o_bit ? (i_rem - w_d_ext) : i_rem;
  // After the subtract rem < d < 2^WIDTH, so the dropped MSB is always zero.
  assign o_next_rem = {o_sub_rem[WIDTH-1:0], 1'b0};

endmodule

// File: rtl/mant_divider_seq.sv
// rtl/mant_divider_seq.sv - sequential restoring mantissa divider, one quotient bit per clock
module mant_divider_seq
  import mant_divider_seq_pkg::*;
#(
  parameter int WIDTH = MANT_WIDTH,
  parameter int QBITS = WIDTH + 2
) (
  input  logic             clk,
  input  logic             reset,
  mant_divider_seq_if.slave div
);

  localparam int CW = $clog2(QBITS);

  logic [1:0]       r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [QBITS-1:0] r_q;
  logic             r_sticky;
  logic             r_busy;
  logic             r_ready;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_bit;
  logic [WIDTH:0]   w_sub_rem;
  logic [WIDTH:0]   w_next_rem;
  logic             w_b_zero;
  logic             w_a_ovf;

  assign w_b_zero = (div.b == '0);
  // A quotient needs at most one integer bit, so a >= 2b cannot be represented.
  assign w_a_ovf  = ({1'b0, div.a} >= {div.b, 1'b0});

  mant_divider_seq_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem      (r_rem),
    .i_d        (r_d),
    .o_bit      (w_bit),
    .o_sub_rem  (w_sub_rem),
    .o_next_rem (w_next_rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_rem    <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_q      <= '0;
      r_sticky <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (div.start) begin
            r_ready  <= 1'b0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
            r_sticky <= 1'b0;
            r_q      <= '0;
            if (w_b_zero) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
              r_dbz   <= 1'b1;
              r_q     <= '1;
            end else if (w_a_ovf) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
              r_ovf   <= 1'b1;
              r_q     <= '1;
            end else begin
              r_rem   <= {1'b0, div.a};
              r_d     <= div.b;
              r_cnt   <= CW'(QBITS - 1);
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_q   <= {r_q[QBITS-2:0], w_bit};
          r_rem <= w_next_rem;
          if (r_cnt == '0) begin
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_sticky <= |w_sub_rem;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign div.q      = r_q;
  assign div.sticky = r_sticky;
  assign div.busy   = r_busy;
  assign div.ready  = r_ready;
  assign div.dbz    = r_dbz;
  assign div.ovf    = r_ovf;

endmodule

// File: tb/tb_mant_divider_seq.sv
// tb/tb_mant_divider_seq.sv - scoreboard bench for mant_divider_seq
module tb_mant_divider_seq;

  localparam int W      = 24;
  localparam int QB     = 26;
  // Cycles from the clock in which start is raised to the first cycle ready is seen.
  localparam int LAT_RUN   = QB + 1;
  localparam int LAT_SHORT = 1;

  typedef struct {
    logic [QB-1:0] q;
    logic          sticky;
    logic          dbz;
    logic          ovf;
    int            lat;
    int            t_start;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  logic prev_ready;
  exp_t sb[$];

  mant_divider_seq_if #(.WIDTH(W), .QBITS(QB)) dif ();

  mant_divider_seq #(.WIDTH(W), .QBITS(QB)) dut (
    .clk   (clk),
    .reset (reset),
    .div   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [QB-1:0] act, input logic [QB-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: each rising edge of ready retires one scoreboard entry.
  initial prev_ready = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (dif.ready === 1'b1 && prev_ready !== 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: ready rose with empty scoreboard, q=0x%0h", dif.q);
      end else begin
        e = sb.pop_front();
        check("q",       dif.q, e.q);
        check("sticky",  QB'(dif.sticky), QB'(e.sticky));
        check("dbz",     QB'(dif.dbz), QB'(e.dbz));
        check("ovf",     QB'(dif.ovf), QB'(e.ovf));
        check("latency", QB'(cyc - e.t_start), QB'(e.lat));
      end
    end
    prev_ready = dif.ready;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic push,
                       input logic [QB-1:0] q, input logic st, input logic dz,
                       input logic ov, input int lat);
    exp_t e;
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = a;
    dif.b     = b;
    if (push) begin
      e.q = q; e.sticky = st; e.dbz = dz; e.ovf = ov; e.lat = lat; e.t_start = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: %0d results pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_q"},      dif.q, '0);
    check({tag, "_sticky"}, QB'(dif.sticky), '0);
    check({tag, "_busy"},   QB'(dif.busy), '0);
    check({tag, "_ready"},  QB'(dif.ready), '0);
    check({tag, "_dbz"},    QB'(dif.dbz), '0);
    check({tag, "_ovf"},    QB'(dif.ovf), '0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    dif.start = 1'b0;
    dif.a = '0;
    dif.b = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // 1.0 / 1.0
    issue(24'h800000, 24'h800000, 1'b1, 26'h2000000, 1'b0, 1'b0, 1'b0, LAT_RUN);
    wait_result("one_by_one");
    repeat (5) @(negedge clk);
    check("hold_q", dif.q, 26'h2000000);
    check("hold_ready", QB'(dif.ready), QB'(1));

    // 1.5 / 1.0, then 1.0 / 1.5 issued straight from DONE
    issue(24'hC00000, 24'h800000, 1'b1, 26'h3000000, 1'b0, 1'b0, 1'b0, LAT_RUN);
    wait_result("1p5_by_1");
    issue(24'h800000, 24'hC00000, 1'b1, 26'h1555555, 1'b1, 1'b0, 1'b0, LAT_RUN);
    wait_result("1_by_1p5");

    // max / 1.0 with a stray start mid-run
    issue(24'hFFFFFF, 24'h800000, 1'b1, 26'h3FFFFFC, 1'b0, 1'b0, 1'b0, LAT_RUN);
    repeat (9) @(negedge clk);
    check("busy_mid_run", QB'(dif.busy), QB'(1));
    dif.start = 1'b1;
    dif.a = 24'h000123;
    dif.b = 24'h000001;
    @(negedge clk);
    dif.start = 1'b0;
    wait_result("max_by_1");

    pulse_reset();
    issue(24'h123456, 24'h000000, 1'b1, 26'h3FFFFFF, 1'b0, 1'b1, 1'b0, LAT_SHORT);
    wait_result("dbz");

    pulse_reset();
    issue(24'h000002, 24'h000001, 1'b1, 26'h3FFFFFF, 1'b0, 1'b0, 1'b1, LAT_SHORT);
    wait_result("ovf");

    // asynchronous reset in the middle of a run
    pulse_reset();
    issue(24'h800000, 24'h800000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
    repeat (11) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue(24'h800000, 24'h800000, 1'b1, 26'h2000000, 1'b0, 1'b0, 1'b0, LAT_RUN);
    wait_result("after_abort");

    // zero dividend is a normal full-latency run
    issue(24'h000000, 24'h800000, 1'b1, 26'h0000000, 1'b0, 1'b0, 1'b0, LAT_RUN);
    wait_result("zero_dividend");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
